si_inst_fetch: RTL and testbench

Single-issue instruction fetch unit. Produces the 32-bit instruction word consumed by the instruction decoder. Owns the PC and issues one instruction-memory request at a time over a valid/ready request plus valid-only response channel. Takes branch/jump redirects resolved downstream, discards in-flight wrong-path fetches, and holds the fetched instruction while the pipeline stalls.

---
 rtl/si_inst_fetch.sv | 104 ++++++++++
 tb/tb_si_inst_fetch.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/si_inst_fetch.sv
// Single-issue instruction fetch: owns the PC, keeps one memory request in flight,
// drops wrong-path responses after a redirect and holds the fetched word while stalled.
module si_inst_fetch #(
   parameter int                 INST_DW  = 32,
   parameter int                 INST_AW  = 32,
   parameter logic [INST_AW-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req_valid_o,
   input  logic               imem_req_ready_i,
   output logic [INST_AW-1:0] imem_req_addr_o,
   input  logic               imem_rsp_valid_i,
   input  logic [INST_DW-1:0] imem_rsp_data_i,
   input  logic               redirect_en_i,
   input  logic [INST_AW-1:0] redirect_pc_i,
   input  logic               stall_i,
   output logic               inst_valid_o,
   output logic [INST_DW-1:0] inst_o,
   output logic [INST_AW-1:0] inst_pc_o
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_WAIT = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam logic [INST_DW-1:0] NOP_WORD = INST_DW'(32'h0000_0013);
   localparam logic [INST_AW-1:0] PC_STEP  = INST_AW'(4);
   localparam logic [INST_AW-1:0] ALIGN_MASK = ~INST_AW'(3);

   logic [1:0]         state;
   logic [INST_AW-1:0] pc;
   logic               drop_q;
   logic [INST_AW-1:0] redirect_tgt;

   // Targets are forced word-aligned; the low bits of the request are ignored.
   assign redirect_tgt = redirect_pc_i & ALIGN_MASK;

   assign imem_req_valid_o = (state == ST_REQ);
   assign imem_req_addr_o  = pc;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_BOOT;
         pc           <= RESET_PC;
         drop_q       <= 1'b0;
         inst_valid_o <= 1'b0;
         inst_o       <= NOP_WORD;
         inst_pc_o    <= '0;
      end else begin
         case (state)
            ST_BOOT: begin
               state <= ST_REQ;
            end
            ST_REQ: begin
               if (redirect_en_i) begin
                  pc <= redirect_tgt;
               end
               // A redirect in the acceptance cycle means the old address is in flight.
               if (imem_req_ready_i) begin
                  drop_q <= redirect_en_i;
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid_i) begin
                  if (drop_q || redirect_en_i) begin
                     drop_q <= 1'b0;
                     if (redirect_en_i) begin
                        pc <= redirect_tgt;
                     end
                     state <= ST_REQ;
                  end else begin
                     inst_o       <= imem_rsp_data_i;
                     inst_pc_o    <= pc;
                     pc           <= pc + PC_STEP;
                     inst_valid_o <= 1'b1;
                     state        <= ST_HOLD;
                  end
               end else if (redirect_en_i) begin
                  pc     <= redirect_tgt;
                  drop_q <= 1'b1;
               end
            end
            ST_HOLD: begin
               // Redirect wins over consumption: the held word is abandoned either way.
               if (redirect_en_i) begin
                  pc           <= redirect_tgt;
                  inst_valid_o <= 1'b0;
                  state        <= ST_REQ;
               end else if (!stall_i) begin
                  inst_valid_o <= 1'b0;
                  state        <= ST_REQ;
               end
            end
            default: begin
               state <= ST_BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_si_inst_fetch.sv
// Self-checking bench for si_inst_fetch: directed scenarios followed by a randomized
// run checked against a program-order fetch model and a simple memory responder.
module tb_si_inst_fetch;

   logic        clk;
   logic        rst;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [31:0] imem_rsp_data_i;
   logic        redirect_en_i;
   logic [31:0] redirect_pc_i;
   logic        stall_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_pc_o;

   int n_cmp  = 0;
   int n_fail = 0;

   si_inst_fetch #(
      .INST_DW (32),
      .INST_AW (32),
      .RESET_PC(32'h8000_0000)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid_o(imem_req_valid_o),
      .imem_req_ready_i(imem_req_ready_i),
      .imem_req_addr_o (imem_req_addr_o),
      .imem_rsp_valid_i(imem_rsp_valid_i),
      .imem_rsp_data_i (imem_rsp_data_i),
      .redirect_en_i   (redirect_en_i),
      .redirect_pc_i   (redirect_pc_i),
      .stall_i         (stall_i),
      .inst_valid_o    (inst_valid_o),
      .inst_o          (inst_o),
      .inst_pc_o       (inst_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".req_valid"},  {31'd0, imem_req_valid_o}, 32'd0);
      chk({tag, ".req_addr"},   imem_req_addr_o,            32'h8000_0000);
      chk({tag, ".inst_valid"}, {31'd0, inst_valid_o},     32'd0);
      chk({tag, ".inst"},       inst_o,                     32'h0000_0013);
      chk({tag, ".inst_pc"},    inst_pc_o,                  32'h0000_0000);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
   endfunction

   // Watchdog: the run is a fixed number of cycles, this only guards against a stuck simulator.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_pc;
      logic        outstanding;
      logic [31:0] out_addr;
      int          delay;
      int          deliveries;
      logic        prev_valid, prev_stall, prev_redir;
      logic [31:0] prev_inst, prev_pc, tgt;

      rst = 1'b0;
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'h0;
      redirect_en_i    = 1'b0;
      redirect_pc_i    = 32'h0;
      stall_i          = 1'b0;
      cyc();
      cyc();
      chk_reset("reset");
      #3 rst = 1'b1;

      // Test 1: first fetch after boot
      cyc();
      chk("t1.req_valid", {31'd0, imem_req_valid_o}, 32'd1);
      chk("t1.req_addr", imem_req_addr_o, 32'h8000_0000);
      imem_req_ready_i = 1'b1;
      cyc();
      chk("t1.wait_req_valid", {31'd0, imem_req_valid_o}, 32'd0);
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'h0050_0093;
      cyc();
      imem_rsp_valid_i = 1'b0;
      chk("t1.inst_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("t1.inst", inst_o, 32'h0050_0093);
      chk("t1.inst_pc", inst_pc_o, 32'h8000_0000);
      cyc();
      chk("t1.next_req_valid", {31'd0, imem_req_valid_o}, 32'd1);
      chk("t1.next_req_addr", imem_req_addr_o, 32'h8000_0004);
      chk("t1.consumed", {31'd0, inst_valid_o}, 32'd0);

      // Test 2: stall while holding the second instruction
      imem_req_ready_i = 1'b1;
      cyc();
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'h00A0_0113;
      cyc();
      imem_rsp_valid_i = 1'b0;
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("t2.inst_valid", {31'd0, inst_valid_o}, 32'd1);
         chk("t2.inst", inst_o, 32'h00A0_0113);
         chk("t2.inst_pc", inst_pc_o, 32'h8000_0004);
         chk("t2.req_valid", {31'd0, imem_req_valid_o}, 32'd0);
         cyc();
      end
      chk("t2.still_held", {31'd0, inst_valid_o}, 32'd1);
      stall_i = 1'b0;
      cyc();
      chk("t2.req_valid_after", {31'd0, imem_req_valid_o}, 32'd1);
      chk("t2.req_addr_after", imem_req_addr_o, 32'h8000_0008);

      // Test 3: redirect in WAIT, stale response discarded
      imem_req_ready_i = 1'b1;
      cyc();
      imem_req_ready_i = 1'b0;
      redirect_en_i = 1'b1;
      redirect_pc_i = 32'h8000_0100;
      cyc();
      redirect_en_i = 1'b0;
      chk("t3.no_inst_a", {31'd0, inst_valid_o}, 32'd0);
      cyc();
      chk("t3.no_inst_b", {31'd0, inst_valid_o}, 32'd0);
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'hDEAD_BEEF;
      cyc();
      imem_rsp_valid_i = 1'b0;
      chk("t3.no_inst_c", {31'd0, inst_valid_o}, 32'd0);
      chk("t3.req_valid", {31'd0, imem_req_valid_o}, 32'd1);
      chk("t3.req_addr", imem_req_addr_o, 32'h8000_0100);

      // Test 4: redirect in the acceptance cycle
      redirect_en_i = 1'b1;
      redirect_pc_i = 32'h8000_0010;
      cyc();
      chk("t4.req_addr_old", imem_req_addr_o, 32'h8000_0010);
      chk("t4.req_valid_old", {31'd0, imem_req_valid_o}, 32'd1);
      redirect_pc_i = 32'h8000_0200;
      imem_req_ready_i = 1'b1;
      cyc();
      redirect_en_i = 1'b0;
      imem_req_ready_i = 1'b0;
      chk("t4.wait", {31'd0, imem_req_valid_o}, 32'd0);
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'h1111_1111;
      cyc();
      imem_rsp_valid_i = 1'b0;
      chk("t4.no_inst", {31'd0, inst_valid_o}, 32'd0);
      chk("t4.req_valid", {31'd0, imem_req_valid_o}, 32'd1);
      chk("t4.req_addr", imem_req_addr_o, 32'h8000_0200);

      // Test 5: asynchronous reset mid-WAIT, late response ignored
      imem_req_ready_i = 1'b1;
      cyc();
      imem_req_ready_i = 1'b0;
      #2 rst = 1'b0;
      #1 chk_reset("t5.async");
      #2 rst = 1'b1;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'hCAFE_BABE;
      cyc();
      chk("t5.req_valid", {31'd0, imem_req_valid_o}, 32'd1);
      chk("t5.req_addr", imem_req_addr_o, 32'h8000_0000);
      chk("t5.no_inst", {31'd0, inst_valid_o}, 32'd0);
      cyc();
      imem_rsp_valid_i = 1'b0;
      chk("t5.req_still", {31'd0, imem_req_valid_o}, 32'd1);
      chk("t5.no_inst_req", {31'd0, inst_valid_o}, 32'd0);
      chk("t5.inst_nop", inst_o, 32'h0000_0013);

      // Test 6: unaligned redirect and PC wrap
      redirect_en_i = 1'b1;
      redirect_pc_i = 32'hFFFF_FFFE;
      cyc();
      redirect_en_i = 1'b0;
      chk("t6.req_addr", imem_req_addr_o, 32'hFFFF_FFFC);
      imem_req_ready_i = 1'b1;
      cyc();
      imem_req_ready_i = 1'b0;
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = 32'h1234_5678;
      cyc();
      imem_rsp_valid_i = 1'b0;
      chk("t6.inst", inst_o, 32'h1234_5678);
      chk("t6.inst_pc", inst_pc_o, 32'hFFFF_FFFC);
      cyc();
      chk("t6.wrap_valid", {31'd0, imem_req_valid_o}, 32'd1);
      chk("t6.wrap_addr", imem_req_addr_o, 32'h0000_0000);

      // Randomized run: instructions must appear in program order from the last redirect.
      exp_pc      = 32'h0000_0000;
      outstanding = 1'b0;
      out_addr    = 32'h0;
      delay       = 0;
      deliveries  = 0;
      prev_valid  = 1'b0;
      prev_stall  = 1'b0;
      prev_redir  = 1'b0;
      prev_inst   = 32'h0;
      prev_pc     = 32'h0;
      for (int c = 0; c < 1500; c++) begin
         if (imem_req_valid_o) begin
            chk("rnd.req_addr", imem_req_addr_o, exp_pc);
            chk("rnd.single_outstanding", {31'd0, outstanding}, 32'd0);
            chk("rnd.req_vs_inst", {31'd0, inst_valid_o}, 32'd0);
         end
         if (prev_valid) begin
            chk("rnd.hold_valid", {31'd0, inst_valid_o}, {31'd0, prev_stall & ~prev_redir});
         end
         if (inst_valid_o && prev_valid) begin
            chk("rnd.hold_inst", inst_o, prev_inst);
            chk("rnd.hold_pc", inst_pc_o, prev_pc);
         end else if (inst_valid_o) begin
            chk("rnd.deliver_pc", inst_pc_o, exp_pc);
            chk("rnd.deliver_inst", inst_o, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            deliveries++;
         end
         prev_valid = inst_valid_o;
         prev_inst  = inst_o;
         prev_pc    = inst_pc_o;

         imem_rsp_valid_i = 1'b0;
         imem_rsp_data_i  = $urandom;
         if (outstanding) begin
            if (delay == 0) begin
               imem_rsp_valid_i = 1'b1;
               imem_rsp_data_i  = mem_word(out_addr);
               outstanding      = 1'b0;
            end else begin
               delay--;
            end
         end
         imem_req_ready_i = $urandom_range(0, 1) == 1;
         if (imem_req_valid_o && imem_req_ready_i) begin
            outstanding = 1'b1;
            out_addr    = imem_req_addr_o;
            delay       = $urandom_range(0, 3);
         end
         stall_i       = $urandom_range(0, 1) == 1;
         redirect_en_i = $urandom_range(0, 7) == 0;
         tgt = $urandom;
         if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
         redirect_pc_i = tgt;
         if (redirect_en_i) exp_pc = tgt & 32'hFFFF_FFFC;
         prev_stall = stall_i;
         prev_redir = redirect_en_i;
         cyc();
      end
      chk("rnd.progress", {31'd0, deliveries >= 20}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
